onehot_codec_pipe: RTL

//  Parametrised, pipelined binary<->one-hot converter with a valid/ready stream interface.
//  Per-word mode: decode (binary index -> one-hot vector) or encode (one-hot -> binary index).

---
 rtl/onehot_codec_pkg.sv | 15 +
 rtl/onehot_pipe_stage.sv | 34 +++
 rtl/onehot_codec_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/onehot_codec_pkg.sv
// Shared constants and configuration checks for the one-hot codec pipeline.
package onehot_codec_pkg;

    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_ENC = 1'b1;

    localparam int BIN_W_MIN = 1;
    localparam int BIN_W_MAX = 8;

    // Legal binary index widths; beyond 8 the one-hot side becomes impractically wide.
    function automatic bit bin_w_ok(input int w);
        return (w >= BIN_W_MIN) && (w <= BIN_W_MAX);
    endfunction

endpackage

// File: rtl/onehot_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus data register with valid/ready handshake.
module onehot_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              vld;
    logic [DATA_W-1:0] data;

    // Slot can take a word when empty or when its current word leaves this cycle.
    assign in_ready  = !vld || out_ready;
    assign out_valid = vld;
    assign out_data  = data;

    // Load on accept; data is held otherwise so backpressured outputs stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (in_ready) begin
            vld <= in_valid;
            if (in_valid) data <= in_data;
        end
    end

endmodule

// File: rtl/onehot_codec_pipe.sv
// Pipelined binary<->one-hot converter with valid/ready stream interface.
// Slot 0 captures the raw word, conversion sits between slots 0 and 1,
// remaining slots are pure elastic delay.
module onehot_codec_pipe
    import onehot_codec_pkg::*;
#(
    parameter int BIN_W     = 6,
    parameter int STAGES    = 2,
    parameter int ERR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [BIN_W-1:0]       in_bin,
    input  logic [(1<<BIN_W)-1:0]  in_oh,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mode,
    output logic [BIN_W-1:0]       out_bin,
    output logic [(1<<BIN_W)-1:0]  out_oh,
    output logic                   out_err,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam int OH_W   = 1 << BIN_W;
    localparam int DATA_W = 1 + BIN_W + OH_W + 1;   // {mode, bin, oh, err}
    localparam logic [OH_W-1:0] OH_ONE = {{(OH_W-1){1'b0}}, 1'b1};

    if (!bin_w_ok(BIN_W) || STAGES < 2 || STAGES > 4) begin : g_cfg_err
        $error("onehot_codec_pipe: unsupported BIN_W or STAGES");
    end

    // Index of lowest set bit, 0 when the vector is empty.
    function automatic logic [BIN_W-1:0] lowest_idx(input logic [OH_W-1:0] v);
        logic [BIN_W-1:0] idx;
        idx = '0;
        for (int i = OH_W - 1; i >= 0; i--)
            if (v[i]) idx = i[BIN_W-1:0];
        return idx;
    endfunction

    // True when exactly one bit is set (popcount == 1).
    function automatic logic onehot_ok(input logic [OH_W-1:0] v);
        return (v != '0) && ((v & (v - OH_ONE)) == '0);
    endfunction

    logic [STAGES-1:0]             v_in, v_out, r_in, r_out;
    logic [STAGES-1:0][DATA_W-1:0] d_in, d_out;

    logic              raw_mode;
    logic [BIN_W-1:0]  raw_bin, cv_bin;
    logic [OH_W-1:0]   raw_oh;
    logic              cv_err;
    logic [DATA_W-1:0] conv;

    assign raw_mode = d_out[0][DATA_W-1];
    assign raw_bin  = d_out[0][OH_W+BIN_W:OH_W+1];
    assign raw_oh   = d_out[0][OH_W:1];

    // Convert the word held in slot 0 into its canonical {bin, clean one-hot, err} form.
    always_comb begin
        cv_bin = raw_bin;
        cv_err = 1'b0;
        if (raw_mode == MODE_ENC) begin
            cv_bin = lowest_idx(raw_oh);
            cv_err = !onehot_ok(raw_oh);
        end
        conv = {raw_mode, cv_bin, OH_ONE << cv_bin, cv_err};
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign v_in[i] = in_valid;
            assign d_in[i] = {in_mode, in_bin, in_oh, 1'b0};
        end else if (i == 1) begin : g_conv
            assign v_in[i] = v_out[i-1];
            assign d_in[i] = conv;
        end else begin : g_delay
            assign v_in[i] = v_out[i-1];
            assign d_in[i] = d_out[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign r_out[i] = out_ready;
        end else begin : g_link
            assign r_out[i] = r_in[i+1];
        end

        onehot_pipe_stage #(.DATA_W(DATA_W)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v_in[i]),
            .in_ready  (r_in[i]),
            .in_data   (d_in[i]),
            .out_valid (v_out[i]),
            .out_ready (r_out[i]),
            .out_data  (d_out[i])
        );
    end

    assign in_ready  = r_in[0];
    assign out_valid = v_out[STAGES-1];
    assign out_mode  = d_out[STAGES-1][DATA_W-1];
    assign out_bin   = d_out[STAGES-1][OH_W+BIN_W:OH_W+1];
    assign out_oh    = d_out[STAGES-1][OH_W:1];
    assign out_err   = d_out[STAGES-1][0];

    // Count errored words as they leave; saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (out_valid && out_ready && out_err && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
    end

endmodule
